// File: rtl/jellyvl_etherneco_ring_scheduler.sv
// EtherNeco ring master transmit scheduler: periodic synctimer packets plus user packets,
// with a single packet outstanding until its response or a timeout.
module jellyvl_etherneco_ring_scheduler #(
  parameter int unsigned TIMER_WIDTH   = 64,
  parameter int unsigned PERIOD_WIDTH  = 32,
  parameter int unsigned TIMEOUT_WIDTH = 24,
  parameter logic [7:0]  SYNC_TYPE     = 8'h10,
  parameter logic [15:0] SYNC_LENGTH   = 16'd16,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [TIMER_WIDTH-1:0]   current_time,
  input  logic [PERIOD_WIDTH-1:0]  param_period,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  input  logic                     usr_req,
  input  logic [7:0]               usr_type,
  input  logic [15:0]              usr_length,
  output logic                     usr_grant,
  output logic                     m_tx_start,
  output logic [7:0]               m_tx_type,
  output logic [15:0]              m_tx_length,
  input  logic                     m_tx_ready,
  input  logic                     res_rx_end,
  input  logic                     res_rx_error,
  output logic                     busy,
  output logic [COUNT_WIDTH-1:0]   sync_miss_cnt,
  output logic [COUNT_WIDTH-1:0]   timeout_cnt,
  output logic [COUNT_WIDTH-1:0]   error_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RES = 2'd2
  } state_t;

  state_t                   state_r;
  logic [TIMER_WIDTH-1:0]   next_time_r;
  logic                     armed_r;
  logic                     is_user_r;
  logic [TIMEOUT_WIDTH-1:0] wait_r;

  logic [TIMER_WIDTH-1:0]        period_ext_s;
  logic [TIMER_WIDTH-1:0]        next_adv_s;
  logic [TIMER_WIDTH-1:0]        rearm_time_s;
  logic signed [TIMER_WIDTH-1:0] due_diff_s;
  logic signed [TIMER_WIDTH-1:0] adv_diff_s;
  logic                          period_on_s;
  logic                          due_s;
  logic                          adv_late_s;
  logic                          timeout_hit_s;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == {COUNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + COUNT_WIDTH'(1);
    end
  endfunction

  // Deadline comparisons are done by modular subtraction so they stay correct across timer wrap.
  assign period_ext_s  = TIMER_WIDTH'(param_period);
  assign period_on_s   = (param_period != PERIOD_WIDTH'(0));
  assign next_adv_s    = next_time_r + period_ext_s;
  assign rearm_time_s  = current_time + period_ext_s;
  assign due_diff_s    = $signed(current_time - next_time_r);
  assign adv_diff_s    = $signed(current_time - next_adv_s);
  assign due_s         = armed_r && period_on_s && (due_diff_s >= $signed({TIMER_WIDTH{1'b0}}));
  assign adv_late_s    = (adv_diff_s >= $signed({TIMER_WIDTH{1'b0}}));
  assign timeout_hit_s = (param_timeout != TIMEOUT_WIDTH'(0))
                      && (wait_r == (param_timeout - TIMEOUT_WIDTH'(1)));

  // Deadline tracking, packet FSM and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      next_time_r   <= {TIMER_WIDTH{1'b0}};
      armed_r       <= 1'b0;
      is_user_r     <= 1'b0;
      wait_r        <= {TIMEOUT_WIDTH{1'b0}};
      usr_grant     <= 1'b0;
      m_tx_start    <= 1'b0;
      m_tx_type     <= 8'h00;
      m_tx_length   <= 16'h0000;
      busy          <= 1'b0;
      sync_miss_cnt <= {COUNT_WIDTH{1'b0}};
      timeout_cnt   <= {COUNT_WIDTH{1'b0}};
      error_cnt     <= {COUNT_WIDTH{1'b0}};
    end else begin
      usr_grant <= 1'b0;

      if (!enable || !period_on_s) begin
        armed_r <= 1'b0;
      end else if (!armed_r) begin
        next_time_r <= rearm_time_s;
        armed_r     <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (enable && due_s) begin
            state_r     <= ST_ISSUE;
            busy        <= 1'b1;
            m_tx_start  <= 1'b1;
            m_tx_type   <= SYNC_TYPE;
            m_tx_length <= SYNC_LENGTH;
            is_user_r   <= 1'b0;
            // Advance drift free; if still behind by a full period, skip ahead from now.
            if (adv_late_s) begin
              next_time_r   <= rearm_time_s;
              sync_miss_cnt <= sat_inc(sync_miss_cnt);
            end else begin
              next_time_r   <= next_adv_s;
            end
          end else if (enable && usr_req) begin
            state_r     <= ST_ISSUE;
            busy        <= 1'b1;
            m_tx_start  <= 1'b1;
            m_tx_type   <= usr_type;
            m_tx_length <= usr_length;
            is_user_r   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (m_tx_start && m_tx_ready) begin
            state_r    <= ST_WAIT_RES;
            m_tx_start <= 1'b0;
            usr_grant  <= is_user_r;
            wait_r     <= {TIMEOUT_WIDTH{1'b0}};
          end
        end
        ST_WAIT_RES: begin
          // A response arriving together with the timeout wins.
          if (res_rx_end) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            if (res_rx_error) begin
              error_cnt <= sat_inc(error_cnt);
            end
          end else if (timeout_hit_s) begin
            state_r     <= ST_IDLE;
            busy        <= 1'b0;
            timeout_cnt <= sat_inc(timeout_cnt);
          end else begin
            wait_r <= wait_r + TIMEOUT_WIDTH'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          m_tx_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jellyvl_etherneco_ring_scheduler.sv
// Directed self-checking bench for jellyvl_etherneco_ring_scheduler.
module tb_jellyvl_etherneco_ring_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] current_time;
  logic [31:0] param_period;
  logic [23:0] param_timeout;
  logic        usr_req;
  logic [7:0]  usr_type;
  logic [15:0] usr_length;
  logic        usr_grant;
  logic        m_tx_start;
  logic [7:0]  m_tx_type;
  logic [15:0] m_tx_length;
  logic        m_tx_ready;
  logic        res_rx_end;
  logic        res_rx_error;
  logic        busy;
  logic [15:0] sync_miss_cnt;
  logic [15:0] timeout_cnt;
  logic [15:0] error_cnt;

  int checks = 0;
  int errors = 0;
  bit time_run = 1'b0;

  int          rec_cnt;
  int          rec_badfmt;
  int          rec_n [4];
  logic [63:0] rec_t [4];

  always #5 clk = ~clk;

  jellyvl_etherneco_ring_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .current_time  (current_time),
    .param_period  (param_period),
    .param_timeout (param_timeout),
    .usr_req       (usr_req),
    .usr_type      (usr_type),
    .usr_length    (usr_length),
    .usr_grant     (usr_grant),
    .m_tx_start    (m_tx_start),
    .m_tx_type     (m_tx_type),
    .m_tx_length   (m_tx_length),
    .m_tx_ready    (m_tx_ready),
    .res_rx_end    (res_rx_end),
    .res_rx_error  (res_rx_error),
    .busy          (busy),
    .sync_miss_cnt (sync_miss_cnt),
    .timeout_cnt   (timeout_cnt),
    .error_cnt     (error_cnt)
  );

  // One clock; outputs are sampled 1 ns after the edge, then the timer advances.
  task automatic step();
    @(posedge clk);
    #1;
    if (time_run) current_time = current_time + 64'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; current_time = 64'd0; param_period = 32'd0;
    param_timeout = 24'd0; usr_req = 1'b0; usr_type = 8'h00; usr_length = 16'd0;
    m_tx_ready = 1'b0; res_rx_end = 1'b0; res_rx_error = 1'b0; time_run = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Runs the ring with ready=1, answering each packet 10 clk after it starts.
  task automatic run_ring(input int ncyc);
    int cd;
    cd = 0; rec_cnt = 0; rec_badfmt = 0;
    for (int n = 1; n <= ncyc; n++) begin
      step();
      res_rx_end = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) res_rx_end = 1'b1;
      end
      if (m_tx_start) begin
        if (rec_cnt < 4) begin
          rec_n[rec_cnt] = n;
          rec_t[rec_cnt] = current_time - 64'd1;
        end
        rec_cnt++;
        if (m_tx_type !== 8'h10 || m_tx_length !== 16'd16) rec_badfmt++;
        cd = 10;
      end
    end
    res_rx_end = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", m_tx_start); end
    checks++; if (usr_grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", usr_grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (m_tx_type !== 8'h00 || m_tx_length !== 16'd0) begin errors++; $display("FAIL reset_typelen: got %h/%0d expected 00/0", m_tx_type, m_tx_length); end
    checks++; if (sync_miss_cnt !== 16'd0 || timeout_cnt !== 16'd0 || error_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", sync_miss_cnt, timeout_cnt, error_cnt); end
  endtask

  task automatic test_periodic();
    do_reset();
    current_time = 64'd1000; param_period = 32'd100; m_tx_ready = 1'b1; enable = 1'b1; time_run = 1'b1;
    run_ring(320);
    checks++; if (rec_cnt !== 3) begin errors++; $display("FAIL periodic_count: got %0d expected 3", rec_cnt); end
    checks++; if (rec_n[0] !== 101) begin errors++; $display("FAIL periodic_first: got %0d expected 101", rec_n[0]); end
    checks++; if (rec_n[1] !== 201) begin errors++; $display("FAIL periodic_second: got %0d expected 201", rec_n[1]); end
    checks++; if (rec_n[2] !== 301) begin errors++; $display("FAIL periodic_third: got %0d expected 301", rec_n[2]); end
    checks++; if (rec_badfmt !== 0) begin errors++; $display("FAIL periodic_format: got %0d bad expected 0", rec_badfmt); end
  endtask

  task automatic test_tie();
    int extra;
    do_reset();
    current_time = 64'd5000; param_period = 32'd100; m_tx_ready = 1'b1; enable = 1'b1; time_run = 1'b1;
    usr_type = 8'h22; usr_length = 16'd64;
    repeat (100) step();
    usr_req = 1'b1;
    step();
    checks++; if (m_tx_start !== 1'b1 || m_tx_type !== 8'h10) begin errors++; $display("FAIL tie_sync_first: got start=%b type=%h expected 1/10", m_tx_start, m_tx_type); end
    step();
    checks++; if (usr_grant !== 1'b0 || m_tx_start !== 1'b0) begin errors++; $display("FAIL tie_sync_hs: got grant=%b start=%b expected 0/0", usr_grant, m_tx_start); end
    step(); step();
    res_rx_end = 1'b1;
    step();
    res_rx_end = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_idle: got busy=%b expected 0", busy); end
    step();
    checks++; if (m_tx_start !== 1'b1 || m_tx_type !== 8'h22 || m_tx_length !== 16'd64) begin errors++; $display("FAIL tie_user: got %b/%h/%0d expected 1/22/64", m_tx_start, m_tx_type, m_tx_length); end
    step();
    checks++; if (usr_grant !== 1'b1) begin errors++; $display("FAIL tie_grant: got %b expected 1", usr_grant); end
    usr_req = 1'b0;
    extra = 0;
    repeat (5) begin step(); if (usr_grant || m_tx_start) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL tie_grant_pulse: got %0d extra expected 0", extra); end
  endtask

  task automatic test_ready_stall();
    int stable;
    int extra;
    do_reset();
    enable = 1'b1; usr_req = 1'b1; usr_type = 8'h33; usr_length = 16'd200;
    step();
    stable = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_tx_start === 1'b1 && m_tx_type === 8'h33 && m_tx_length === 16'd200) stable++;
      if (i == 5) m_tx_ready = 1'b1;
      step();
    end
    checks++; if (stable !== 6) begin errors++; $display("FAIL stall_stable: got %0d expected 6", stable); end
    checks++; if (m_tx_start !== 1'b0 || usr_grant !== 1'b1) begin errors++; $display("FAIL stall_hs: got start=%b grant=%b expected 0/1", m_tx_start, usr_grant); end
    usr_req = 1'b0;
    extra = 0;
    repeat (5) begin step(); if (m_tx_start || usr_grant) extra++; end
    checks++; if (extra !== 0 || busy !== 1'b1) begin errors++; $display("FAIL stall_single: got extra=%0d busy=%b expected 0/1", extra, busy); end
  endtask

  task automatic test_timeout();
    int bc;
    do_reset();
    param_timeout = 24'd20; enable = 1'b1; m_tx_ready = 1'b1; usr_req = 1'b1;
    usr_type = 8'h44; usr_length = 16'd8;
    step(); step();
    checks++; if (usr_grant !== 1'b1) begin errors++; $display("FAIL to_grant: got %b expected 1", usr_grant); end
    usr_req = 1'b0;
    bc = 0;
    for (int i = 0; i < 40 && busy; i++) begin bc++; step(); end
    checks++; if (bc !== 20) begin errors++; $display("FAIL to_wait_len: got %0d expected 20", bc); end
    checks++; if (timeout_cnt !== 16'd1) begin errors++; $display("FAIL to_count: got %0d expected 1", timeout_cnt); end
    usr_req = 1'b1;
    step(); step();
    usr_req = 1'b0;
    repeat (19) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_early: got busy=%b expected 1", busy); end
    res_rx_end = 1'b1; res_rx_error = 1'b1;
    step();
    res_rx_end = 1'b0; res_rx_error = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_tie_idle: got busy=%b expected 0", busy); end
    checks++; if (timeout_cnt !== 16'd1) begin errors++; $display("FAIL to_tie_count: got %0d expected 1", timeout_cnt); end
    checks++; if (error_cnt !== 16'd1) begin errors++; $display("FAIL to_err_count: got %0d expected 1", error_cnt); end
  endtask

  task automatic test_jump();
    int n;
    do_reset();
    current_time = 64'd10000; param_period = 32'd100; enable = 1'b1; m_tx_ready = 1'b1; time_run = 1'b1;
    repeat (10) step();
    current_time = current_time + 64'd350;
    step();
    checks++; if (m_tx_start !== 1'b1 || sync_miss_cnt !== 16'd1) begin errors++; $display("FAIL jump_issue: got start=%b miss=%0d expected 1/1", m_tx_start, sync_miss_cnt); end
    step(); step();
    res_rx_end = 1'b1;
    step();
    res_rx_end = 1'b0;
    n = 0;
    while (!m_tx_start && n < 150) begin step(); n++; end
    checks++; if (m_tx_start !== 1'b1 || (current_time - 64'd1) !== 64'd10460) begin errors++; $display("FAIL jump_next: got start=%b time=%0d expected 1/10460", m_tx_start, current_time - 64'd1); end
    checks++; if (sync_miss_cnt !== 16'd1) begin errors++; $display("FAIL jump_miss: got %0d expected 1", sync_miss_cnt); end
  endtask

  task automatic test_wrap_reset();
    int n;
    do_reset();
    current_time = 64'hFFFF_FFFF_FFFF_FFCE; param_period = 32'd100; enable = 1'b1; m_tx_ready = 1'b1; time_run = 1'b1;
    run_ring(250);
    checks++; if (rec_cnt !== 2 || rec_n[0] !== 101) begin errors++; $display("FAIL wrap_count: got %0d starts first=%0d expected 2/101", rec_cnt, rec_n[0]); end
    checks++; if (rec_t[0] !== 64'd50 || rec_t[1] !== 64'd150) begin errors++; $display("FAIL wrap_times: got %0d/%0d expected 50/150", rec_t[0], rec_t[1]); end
    checks++; if (sync_miss_cnt !== 16'd0) begin errors++; $display("FAIL wrap_miss: got %0d expected 0", sync_miss_cnt); end
    n = 0;
    while (!m_tx_start && n < 80) begin step(); n++; end
    step();
    checks++; if (busy !== 1'b1 || m_tx_start !== 1'b0) begin errors++; $display("FAIL wrap_waitres: got busy=%b start=%b expected 1/0", busy, m_tx_start); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || m_tx_start !== 1'b0 || usr_grant !== 1'b0 || m_tx_type !== 8'h00 || m_tx_length !== 16'd0) begin errors++; $display("FAIL midrst_out: got busy=%b start=%b grant=%b type=%h len=%0d expected all 0", busy, m_tx_start, usr_grant, m_tx_type, m_tx_length); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_periodic();
    test_tie();
    test_ready_stall();
    test_timeout();
    test_jump();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
